shift_ex_stage: RTL
===================

# shift_ex_stage

Execute-stage wrapper for the WISC shift/rotate instructions (ROL, SLL, ROR, SRL and their immediate forms). It accepts decoded shift requests from decode over a valid/ready handshake and selects the shift amount from a register or an immediate. It drives a `shifter` instance and buffers results in a 2-entry FIFO toward writeback. An optional bypass forwards the previous result to a dependent back-to-back shift.

## Interface
- `OPERAND_WIDTH`, 16, data width
- `SHAMT_WIDTH`, 4, shift-amount width; must equal log2(`OPERAND_WIDTH`)
- `REG_ADDR_WIDTH`, 3, register specifier width
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  decode presents a request
- `in_ready`  out  1  stage can accept a request
- `in_op`  in  2  00 rotate left, 01 shift left, 10 rotate right, 11 shift right logical
- `in_imm`  in  1  1: amount from `in_shamt_imm`; 0: amount from `in_rt_data`
- `in_shamt_imm`  in  `SHAMT_WIDTH`  immediate shift amount
- `in_rs_addr`  in  `REG_ADDR_WIDTH`  source register specifier (used by the bypass)
- `in_rs_data`  in  `OPERAND_WIDTH`  operand to shift
- `in_rt_data`  in  `OPERAND_WIDTH`  register shift amount; only bits [`SHAMT_WIDTH`-1:0] are used
- `in_rd_addr`  in  `REG_ADDR_WIDTH`  destination register
- `out_valid`  out  1  FIFO head is valid
- `out_ready`  in  1  writeback consumes the head
- `out_data`  out  `OPERAND_WIDTH`  shifted result at the head
- `out_rd_addr`  out  `REG_ADDR_WIDTH`  destination register at the head

## Operation
- Accept occurs when `in_valid & in_ready`.
- Pop occurs when `out_valid & out_ready`.
- Shift amount: `in_imm ? in_shamt_imm : in_rt_data[SHAMT_WIDTH-1:0]`. Upper bits of `in_rt_data` are ignored.
- The operand (`in_rs_data`, or the bypassed value) goes combinationally through `shifter` with `Oper = in_op`. On accept, the result and `in_rd_addr` are written at the FIFO tail.
- The FIFO has 2 entries, with read pointer, write pointer and a 2-bit count, and is strictly in order.
  - Pointers wrap modulo 2.
  - `out_data` and `out_rd_addr` come from the head entry.
- `in_ready = (count != 2)`. It is a function of registered state only; there is no combinational path from `out_ready` to `in_ready`.
- Simultaneous events:
  - Push and pop in the same cycle with count 1: count stays 1. This sustains 1 request/cycle.
  - Count 2 with pop: no push that cycle; count becomes 1.
  - Count 0: `out_valid = 0`; a pop is impossible.
- `in_valid` without `in_ready` is ignored. Decode holds the request stable until it is accepted.
- Shift amount 0 returns the operand unchanged for all ops.

## Timing
- Latency: a request accepted at edge N has `out_valid = 1` with its result during cycle N+1, provided it is at the head.
- Throughput: 1 request/cycle while writeback keeps `out_ready` high.
- Reset values:
  - count 0, both pointers 0
  - `out_valid` 0, `in_ready` 1
  - FIFO data contents are don't-care but are driven as 0 on `out_data` and `out_rd_addr` while empty
  - bypass-valid flag cleared
- Reset mid-operation: all buffered results are discarded. A request presented in the reset cycle is not accepted.

## Configuration
- `SHIFT_FWD_EN` defined:
  - The stage keeps registers `last_vld`, `last_rd` and `last_data`, updated on every accept.
  - If `last_vld & (in_rs_addr == last_rd)`, the operand is `last_data` instead of `in_rs_data`.
  - `last_vld` is cleared by reset only; it persists across idle cycles.
- `SHIFT_FWD_EN` undefined: the operand is always `in_rs_data`, and none of these registers exist.

## Structure
- The shared package holds:
  - the op encoding constants: `SH_ROL` = 2'b00, `SH_SLL` = 2'b01, `SH_ROR` = 2'b10, `SH_SRL` = 2'b11
  - the default widths
- Sub-module: one instance of the existing `shifter`, parameterised with `OPERAND_WIDTH`/`SHAMT_WIDTH` and 2-bit `NUM_OPERATIONS`. The FIFO is inline logic, not a separate module.

## Test plan
- ROL: `in_rs_data`=0x8001, `in_imm`=1, imm=1 -> `out_data`=0x0003 one cycle after accept. ROR: 0x0001 by 1 -> 0x8000.
- SLL: 0x00F0 by imm 4 -> 0x0F00. SRL: 0x8000 with `in_rt_data`=0xFFFF (amount 15) -> 0x0001, showing upper `in_rt_data` bits are ignored.
- Backpressure:
  - With `out_ready`=0, push A then B -> `in_ready`=0 after the second accept. A third request is held.
  - Raise `out_ready` -> A, B and C emerge in order, with no loss or duplication.
- Streaming: `out_ready`=1 with 8 back-to-back requests -> 8 results on 8 consecutive cycles; `in_ready` never drops.
- Reset with 2 entries buffered -> the next cycle shows `out_valid`=0, `in_ready`=1, count 0.
- `SHIFT_FWD_EN`: SLL r1 <- 0x0001 by 1, then next-cycle SLL with rs=r1, `in_rs_data`=0xDEAD, by 1 -> 0x0004. With the macro undefined, the same sequence -> 0xBD5A.

Source files
------------

// File: rtl/shift_ex_stage_pkg.sv
// Shared definitions for the shift execute stage: op encodings and default widths.
// Used by shift_ex_stage and shifter; the SHIFT_FWD_EN build option lives in the top.
package shift_ex_stage_pkg;

  localparam int OPERAND_WIDTH_D  = 16;
  localparam int SHAMT_WIDTH_D    = 4;
  localparam int REG_ADDR_WIDTH_D = 3;

  typedef enum logic [1:0] {
    SH_ROL = 2'b00,
    SH_SLL = 2'b01,
    SH_ROR = 2'b10,
    SH_SRL = 2'b11
  } sh_op_e;

endpackage

// File: rtl/shift_ex_stage_shifter.sv
// Combinational WISC shifter: rotate/shift left/right by a SHAMT_WIDTH-bit amount.
// Rotates use a doubled operand so amount 0 needs no special case.
module shifter
  import shift_ex_stage_pkg::*;
#(
  parameter int OPERAND_WIDTH  = OPERAND_WIDTH_D,
  parameter int SHAMT_WIDTH    = SHAMT_WIDTH_D,
  parameter int NUM_OPERATIONS = 2
) (
  input  logic [OPERAND_WIDTH-1:0]  In,
  input  logic [SHAMT_WIDTH-1:0]    ShAmt,
  input  logic [NUM_OPERATIONS-1:0] Oper,
  output logic [OPERAND_WIDTH-1:0]  Out
);

  logic [2*OPERAND_WIDTH-1:0] w_dbl_l;
  logic [2*OPERAND_WIDTH-1:0] w_dbl_r;

  assign w_dbl_l = {In, In} << ShAmt;
  assign w_dbl_r = {In, In} >> ShAmt;

  always_comb begin
    Out = In;
    case (Oper)
      SH_ROL:  Out = w_dbl_l[2*OPERAND_WIDTH-1:OPERAND_WIDTH];
      SH_SLL:  Out = In << ShAmt;
      SH_ROR:  Out = w_dbl_r[OPERAND_WIDTH-1:0];
      SH_SRL:  Out = In >> ShAmt;
      default: Out = In;
    endcase
  end

endmodule

// File: rtl/shift_ex_stage.sv
// Shift/rotate execute stage: valid/ready intake, shifter, 2-entry in-order result FIFO.
// Define SHIFT_FWD_EN to forward the last accepted result to a dependent request.
module shift_ex_stage
  import shift_ex_stage_pkg::*;
#(
  parameter int OPERAND_WIDTH  = OPERAND_WIDTH_D,
  parameter int SHAMT_WIDTH    = SHAMT_WIDTH_D,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_D
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_op,
  input  logic                      in_imm,
  input  logic [SHAMT_WIDTH-1:0]    in_shamt_imm,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs_addr,
  input  logic [OPERAND_WIDTH-1:0]  in_rs_data,
  input  logic [OPERAND_WIDTH-1:0]  in_rt_data,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPERAND_WIDTH-1:0]  out_data,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready depends only on the registered count, never on out_ready.
  logic [OPERAND_WIDTH-1:0]  r_data [2];
  logic [REG_ADDR_WIDTH-1:0] r_rd   [2];
  logic                      r_rptr;
  logic                      r_wptr;
  logic [1:0]                r_count;

  logic                     w_push;
  logic                     w_pop;
  logic [SHAMT_WIDTH-1:0]   w_shamt;
  logic [OPERAND_WIDTH-1:0] w_operand;
  logic [OPERAND_WIDTH-1:0] w_result;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_shamt   = in_imm ? in_shamt_imm : in_rt_data[SHAMT_WIDTH-1:0];

`ifdef SHIFT_FWD_EN
  logic                      r_last_vld;
  logic [REG_ADDR_WIDTH-1:0] r_last_rd;
  logic [OPERAND_WIDTH-1:0]  r_last_data;
  logic                      w_unused_rt;

  assign w_unused_rt = &{1'b0, in_rt_data[OPERAND_WIDTH-1:SHAMT_WIDTH]};
  assign w_operand   = (r_last_vld && (in_rs_addr == r_last_rd)) ? r_last_data : in_rs_data;

  // Only reset clears the bypass; it survives idle cycles between dependent shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_vld  <= 1'b0;
      r_last_rd   <= '0;
      r_last_data <= '0;
    end else if (w_push) begin
      r_last_vld  <= 1'b1;
      r_last_rd   <= in_rd_addr;
      r_last_data <= w_result;
    end
  end
`else
  logic w_unused_in;

  assign w_unused_in = &{1'b0, in_rt_data[OPERAND_WIDTH-1:SHAMT_WIDTH], in_rs_addr};
  assign w_operand   = in_rs_data;
`endif

  shifter #(
    .OPERAND_WIDTH (OPERAND_WIDTH),
    .SHAMT_WIDTH   (SHAMT_WIDTH),
    .NUM_OPERATIONS(2)
  ) u_shifter (
    .In   (w_operand),
    .ShAmt(w_shamt),
    .Oper (in_op),
    .Out  (w_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr    <= 1'b0;
      r_wptr    <= 1'b0;
      r_count   <= 2'd0;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_rd[0]   <= '0;
      r_rd[1]   <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= w_result;
        r_rd[r_wptr]   <= in_rd_addr;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data    = out_valid ? r_data[r_rptr] : '0;
  assign out_rd_addr = out_valid ? r_rd[r_rptr]   : '0;

endmodule
